// File: rtl/hazard_sched_ctrl.sv
// Pipeline hazard scheduler: load-use stall, taken-branch flush and multi-cycle multiply freeze.
// Define HAZARD_PERF_EN to build the saturating stall-cycle performance counter.
module hazard_sched_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int RW      = 5
) (
    input  logic          clk_i,
    input  logic          start_i,
    input  logic          idex_memread_i,
    input  logic [RW-1:0] idex_rt_i,
    input  logic [RW-1:0] ifid_rs_i,
    input  logic [RW-1:0] ifid_rt_i,
    input  logic          ifid_uses_rt_i,
    input  logic          branch_taken_i,
    input  logic          mul_issue_i,
    output logic          pc_we_o,
    output logic          ifid_we_o,
    output logic          ifid_flush_o,
    output logic          idex_we_o,
    output logic          idex_bubble_o,
    output logic          exmem_bubble_o,
    output logic [1:0]    state_o,
    output logic [31:0]   stall_cycles_o
);

    localparam int CW = $clog2(MUL_LAT) + 1;

    typedef enum logic [1:0] {
        ST_RUN = 2'd0,
        ST_MUL = 2'd1
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lu;

    assign lu = idex_memread_i && (idex_rt_i != '0) &&
                ((idex_rt_i == ifid_rs_i) || (ifid_uses_rt_i && (idex_rt_i == ifid_rt_i)));

    // NOTE: state flops use non-blocking assignment and reset asynchronously so a reset mid-multiply takes effect at once.
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred on any path.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (!lu && !branch_taken_i && mul_issue_i) begin
                    state_d = ST_MUL;
                    cnt_d   = CW'(MUL_LAT - 1);
                end
            end
            ST_MUL: begin
                if (cnt_q == CW'(1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        pc_we_o        = 1'b1;
        ifid_we_o      = 1'b1;
        ifid_flush_o   = 1'b0;
        idex_we_o      = 1'b1;
        idex_bubble_o  = 1'b0;
        exmem_bubble_o = 1'b0;
        if (!start_i) begin
            pc_we_o        = 1'b0;
            ifid_we_o      = 1'b0;
            idex_we_o      = 1'b0;
            idex_bubble_o  = 1'b1;
            exmem_bubble_o = 1'b1;
        end else if (state_q == ST_MUL) begin
            // Front end and ID/EX frozen; the multiply itself keeps EX, so EX/MEM gets bubbles.
            pc_we_o        = 1'b0;
            ifid_we_o      = 1'b0;
            idex_we_o      = 1'b0;
            exmem_bubble_o = 1'b1;
        end else if (lu) begin
            pc_we_o       = 1'b0;
            ifid_we_o     = 1'b0;
            idex_bubble_o = 1'b1;
        end else if (branch_taken_i) begin
            ifid_flush_o = 1'b1;
        end
    end

    assign state_o = state_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_we_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles_o = stall_cnt_q;
`else
    assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_hazard_sched_ctrl.sv
// Scoreboard bench for hazard_sched_ctrl: driver pushes model expectations, monitor pops and compares.
module tb_hazard_sched_ctrl;

    localparam int MUL_LAT = 4;
    localparam int RW      = 5;

    typedef struct packed {
        logic        pc_we;
        logic        ifid_we;
        logic        ifid_flush;
        logic        idex_we;
        logic        idex_bubble;
        logic        exmem_bubble;
        logic [1:0]  state;
        logic [31:0] stalls;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          start_i = 1'b0;
    logic          idex_memread_i = 1'b0;
    logic [RW-1:0] idex_rt_i = '0;
    logic [RW-1:0] ifid_rs_i = '0;
    logic [RW-1:0] ifid_rt_i = '0;
    logic          ifid_uses_rt_i = 1'b0;
    logic          branch_taken_i = 1'b0;
    logic          mul_issue_i = 1'b0;
    logic          pc_we_o, ifid_we_o, ifid_flush_o, idex_we_o, idex_bubble_o, exmem_bubble_o;
    logic [1:0]    state_o;
    logic [31:0]   stall_cycles_o;

    hazard_sched_ctrl #(.MUL_LAT(MUL_LAT), .RW(RW)) dut (
        .clk_i          (clk_i),
        .start_i        (start_i),
        .idex_memread_i (idex_memread_i),
        .idex_rt_i      (idex_rt_i),
        .ifid_rs_i      (ifid_rs_i),
        .ifid_rt_i      (ifid_rt_i),
        .ifid_uses_rt_i (ifid_uses_rt_i),
        .branch_taken_i (branch_taken_i),
        .mul_issue_i    (mul_issue_i),
        .pc_we_o        (pc_we_o),
        .ifid_we_o      (ifid_we_o),
        .ifid_flush_o   (ifid_flush_o),
        .idex_we_o      (idex_we_o),
        .idex_bubble_o  (idex_bubble_o),
        .exmem_bubble_o (exmem_bubble_o),
        .state_o        (state_o),
        .stall_cycles_o (stall_cycles_o)
    );

    always #5 clk_i = ~clk_i;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    // Reference model: remaining frozen cycles of the current multiply and stall edges seen since reset.
    int      freeze_left = 0;
    longint  perf = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, actual, required, $time);
        end
    endtask

    task automatic step(input logic st, input logic mr, input int ert, input int rs, input int rt,
                        input logic ur, input logic br, input logic mu);
        exp_t e;
        logic lu;
        @(negedge clk_i);
        start_i        = st;
        idex_memread_i = mr;
        idex_rt_i      = RW'(ert);
        ifid_rs_i      = RW'(rs);
        ifid_rt_i      = RW'(rt);
        ifid_uses_rt_i = ur;
        branch_taken_i = br;
        mul_issue_i    = mu;
        lu = mr && (ert != 0) && ((ert == rs) || (ur && (ert == rt)));
        if (!st) begin
            freeze_left = 0;
            perf        = 0;
            e = '{pc_we: 0, ifid_we: 0, ifid_flush: 0, idex_we: 0, idex_bubble: 1, exmem_bubble: 1, state: 0, stalls: 0};
        end else if (freeze_left > 0) begin
            e = '{pc_we: 0, ifid_we: 0, ifid_flush: 0, idex_we: 0, idex_bubble: 0, exmem_bubble: 1, state: 1, stalls: 0};
            freeze_left--;
        end else if (lu) begin
            e = '{pc_we: 0, ifid_we: 0, ifid_flush: 0, idex_we: 1, idex_bubble: 1, exmem_bubble: 0, state: 0, stalls: 0};
        end else if (br) begin
            e = '{pc_we: 1, ifid_we: 1, ifid_flush: 1, idex_we: 1, idex_bubble: 0, exmem_bubble: 0, state: 0, stalls: 0};
        end else begin
            e = '{pc_we: 1, ifid_we: 1, ifid_flush: 0, idex_we: 1, idex_bubble: 0, exmem_bubble: 0, state: 0, stalls: 0};
            if (mu) freeze_left = MUL_LAT - 1;
        end
`ifdef HAZARD_PERF_EN
        e.stalls = 32'(perf);
`endif
        if (st && !e.pc_we && perf < 64'hFFFF_FFFF) perf++;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: outputs are combinational, so one response is presented every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ctrl_outs", {24'd0, pc_we_o, ifid_we_o, ifid_flush_o, idex_we_o,
                                    idex_bubble_o, exmem_bubble_o, state_o},
                      {24'd0, e.pc_we, e.ifid_we, e.ifid_flush, e.idex_we,
                       e.idex_bubble, e.exmem_bubble, e.state});
                check("stall_cycles", stall_cycles_o, e.stalls);
            end
        end
    end

    initial begin
        // Reset held with toggled inputs, then release.
        step(0, 1, 8, 8, 8, 1, 1, 1);
        step(0, 0, 3, 3, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 1, 0, 1);
        idle();
        // Load-use stall followed by its non-stalling variants.
        step(1, 1, 8, 8, 0, 0, 0, 0);
        idle();
        // Multiply with a branch held during the freeze.
        step(1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        step(1, 1, 8, 8, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        idle();
        #2;
`ifdef HAZARD_PERF_EN
        check("perf_lu_plus_mul", stall_cycles_o, 32'd4);
`else
        check("perf_disabled", stall_cycles_o, 32'd0);
`endif
        step(1, 1, 0, 0, 0, 1, 0, 0);
        step(1, 1, 8, 3, 8, 0, 0, 0);
        step(1, 1, 8, 3, 8, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        step(1, 1, 8, 8, 0, 0, 1, 1);
        step(1, 0, 0, 0, 0, 0, 1, 1);
        // Back-to-back multiplies, the second issued in the first RUN cycle.
        step(1, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < MUL_LAT - 1; i++) step(1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < MUL_LAT - 1; i++) idle();
        // Reset asserted during the second multiply cycle.
        step(1, 0, 0, 0, 0, 0, 0, 1);
        idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        idle();
        // Randomized traffic on a narrow register range so hazards collide often.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) >= 2, $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0);
        end
        idle();
        @(negedge clk_i);
        #4;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
